// File: rtl/switch_input_pkg.sv
`default_nettype none
// ============================================================================
// Module   : switch_input_pkg
// Brief    : Shared constants, event FSM encoding and a counter-width helper
//            for the slide-switch input reader.
// Revision : 1.0 - initial release
// ============================================================================
package switch_input_pkg;

  localparam int SW_WIDTH           = 16;
  localparam int SW_DEBOUNCE_CYCLES = 1000;
  localparam int SW_STABLE_SAMPLES  = 3;

  typedef enum logic [0:0] {
    EV_IDLE = 1'b0,
    EV_PEND = 1'b1
  } ev_state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : switch_input_pkg
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// ============================================================================
// Module   : input_debounce
// Brief    : One switch bit: 2-flop synchroniser, tick-qualified stability
//            counter and debounced level. o_flip is high on the edge where the
//            debounced level inverts.
// Revision : 1.0 - initial release
// ============================================================================
module input_debounce
  import switch_input_pkg::*;
#(
  parameter int STABLE_SAMPLES = SW_STABLE_SAMPLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_stab,
  output logic o_flip
);

  localparam int CW = cnt_width(STABLE_SAMPLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stab;
  logic [CW-1:0] r_cnt;

  logic w_diff;
  logic w_last;

  // A differing tick that finds the counter at its last value is the one
  // that would make it reach STABLE_SAMPLES, so it inverts the level instead.
  assign w_diff = r_sync2 ^ r_stab;
  assign w_last = (r_cnt == CW'(STABLE_SAMPLES - 1));
  assign o_flip = i_tick & w_diff & w_last;
  assign o_stab = r_stab;

  // Synchronise the raw pin and advance the stability counter on each tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_stab  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (i_tick) begin
        if (w_diff) begin
          if (w_last) begin
            r_stab <= ~r_stab;
            r_cnt  <= '0;
          end else begin
            r_cnt  <= r_cnt + CW'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

endmodule : input_debounce
`default_nettype wire

// File: rtl/switch_input_reader.sv
`default_nettype none
// ============================================================================
// Module   : switch_input_reader
// Brief    : Debounces WIDTH slide switches and reports each debounced change
//            as a valid/ready event. Changes arriving while an event is
//            pending are merged into it, so no change is ever lost.
// Revision : 1.0 - initial release
// ============================================================================
module switch_input_reader
  import switch_input_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
  parameter int STABLE_SAMPLES  = SW_STABLE_SAMPLES
) (
  input  logic             clock_rtl,
  input  logic             reset_rtl_0_1,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_state,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [WIDTH-1:0] ev_state,
  output logic [WIDTH-1:0] ev_mask,
  output logic             ev_coalesced
);

  localparam int TW = cnt_width(DEBOUNCE_CYCLES);

  logic [TW-1:0]    r_tick_cnt;
  logic             w_tick;
  logic [WIDTH-1:0] w_stab;
  logic [WIDTH-1:0] w_flip;
  logic [WIDTH-1:0] w_next_stab;
  logic             w_any_flip;

  ev_state_t        r_fsm;
  logic             r_ev_valid;
  logic [WIDTH-1:0] r_ev_state;
  logic [WIDTH-1:0] r_ev_mask;
  logic             r_ev_coalesced;

  assign w_tick = (r_tick_cnt == TW'(DEBOUNCE_CYCLES - 1));

  // Free-running sample-tick divider; restarts from 0 out of reset.
  always_ff @(posedge clock_rtl) begin
    if (!reset_rtl_0_1) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      input_debounce #(
        .STABLE_SAMPLES (STABLE_SAMPLES)
      ) u_debounce (
        .clk    (clock_rtl),
        .rst_n  (reset_rtl_0_1),
        .i_tick (w_tick),
        .i_raw  (sw_in[gi]),
        .o_stab (w_stab[gi]),
        .o_flip (w_flip[gi])
      );
    end
  endgenerate

  // Debounced levels as they will be after this edge.
  assign w_next_stab = w_stab ^ w_flip;
  assign w_any_flip  = |w_flip;

  assign sw_state     = w_stab;
  assign ev_valid     = r_ev_valid;
  assign ev_state     = r_ev_state;
  assign ev_mask      = r_ev_mask;
  assign ev_coalesced = r_ev_coalesced;

  // Event FSM: raise on a flip, merge later flips until the consumer accepts.
  always_ff @(posedge clock_rtl) begin
    if (!reset_rtl_0_1) begin
      r_fsm          <= EV_IDLE;
      r_ev_valid     <= 1'b0;
      r_ev_state     <= '0;
      r_ev_mask      <= '0;
      r_ev_coalesced <= 1'b0;
    end else begin
      case (r_fsm)
        EV_IDLE: begin
          if (w_any_flip) begin
            r_fsm          <= EV_PEND;
            r_ev_valid     <= 1'b1;
            r_ev_mask      <= w_flip;
            r_ev_state     <= w_next_stab;
            r_ev_coalesced <= 1'b0;
          end
        end
        EV_PEND: begin
          if (ev_ready) begin
            if (w_any_flip) begin
              // Accepted and a new change on the same edge: start afresh.
              r_ev_mask      <= w_flip;
              r_ev_state     <= w_next_stab;
              r_ev_coalesced <= 1'b0;
            end else begin
              r_fsm      <= EV_IDLE;
              r_ev_valid <= 1'b0;
              r_ev_mask  <= '0;
            end
          end else if (w_any_flip) begin
            r_ev_mask      <= r_ev_mask | w_flip;
            r_ev_state     <= w_next_stab;
            r_ev_coalesced <= 1'b1;
          end
        end
        default: begin
          r_fsm      <= EV_IDLE;
          r_ev_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : switch_input_reader
`default_nettype wire

// File: tb/tb_switch_input_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_input_reader
// Brief    : Directed self-checking bench for switch_input_reader with a
//            4-cycle sample tick and 3 stable samples.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_input_reader;

  localparam int W  = 16;
  localparam int DC = 4;
  localparam int SS = 3;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic [W-1:0] sw_in    = 16'hFFFF;
  logic         ev_ready = 1'b1;
  logic [W-1:0] sw_state;
  logic         ev_valid;
  logic [W-1:0] ev_state;
  logic [W-1:0] ev_mask;
  logic         ev_coalesced;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;   // edges since the last reset release

  always #5 clk = ~clk;

  switch_input_reader #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC),
    .STABLE_SAMPLES  (SS)
  ) dut (
    .clock_rtl     (clk),
    .reset_rtl_0_1 (rst_n),
    .sw_in         (sw_in),
    .sw_state      (sw_state),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_state      (ev_state),
    .ev_mask       (ev_mask),
    .ev_coalesced  (ev_coalesced)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int k;
    k = 0;
    while (!ev_valid && k < budget) begin
      step();
      k++;
    end
    check({tag, " valid in budget"}, 32'(ev_valid), 32'd1);
  endtask

  initial begin
    int extra;
    int drops;
    int c0;
    int t1;
    int fl;

    // 1: reset with all switches high, then one event for all bits.
    rst_n    = 1'b0;
    sw_in    = 16'hFFFF;
    ev_ready = 1'b1;
    repeat (5) step();
    check("t1 rst sw_state", 32'(sw_state), 32'h0);
    check("t1 rst ev_valid", 32'(ev_valid), 32'h0);
    check("t1 rst ev_mask", 32'(ev_mask), 32'h0);
    check("t1 rst ev_state", 32'(ev_state), 32'h0);
    check("t1 rst ev_coalesced", 32'(ev_coalesced), 32'h0);
    rst_n = 1'b1;
    cyc   = 0;
    wait_valid(2 + 12, "t1");
    check("t1 ev_mask", 32'(ev_mask), 32'hFFFF);
    check("t1 ev_state", 32'(ev_state), 32'hFFFF);
    check("t1 sw_state", 32'(sw_state), 32'hFFFF);
    check("t1 ev_coalesced", 32'(ev_coalesced), 32'h0);
    step();
    check("t1 valid after accept", 32'(ev_valid), 32'h0);
    extra = 0;
    repeat (20) begin
      step();
      if (ev_valid) extra++;
    end
    check("t1 single event", 32'(extra), 32'h0);

    // 2: clean step of bit 0 with ev_ready held high.
    sw_in = 16'h0000;
    do_reset(3);
    check("t2 sw_state before", 32'(sw_state), 32'h0);
    sw_in = 16'h0001;
    wait_valid(14, "t2");
    check("t2 ev_mask", 32'(ev_mask), 32'h0001);
    check("t2 ev_state", 32'(ev_state), 32'h0001);
    check("t2 sw_state", 32'(sw_state), 32'h0001);
    step();
    check("t2 single-cycle valid", 32'(ev_valid), 32'h0);
    check("t2 sw_state held", 32'(sw_state), 32'h0001);

    // 3: 6-cycle glitch on bit 3 must not be accepted.
    extra = 0;
    sw_in = 16'h0009;
    repeat (6) begin
      step();
      if (ev_valid) extra++;
    end
    sw_in = 16'h0001;
    repeat (30) begin
      step();
      if (ev_valid) extra++;
    end
    check("t3 no event", 32'(extra), 32'h0);
    check("t3 sw_state", 32'(sw_state), 32'h0001);

    // 4: coalescing of bit 0 then bit 5 while the consumer stalls.
    sw_in = 16'h0000;
    do_reset(3);
    ev_ready = 1'b0;
    sw_in    = 16'h0001;
    wait_valid(14, "t4a");
    check("t4a ev_mask", 32'(ev_mask), 32'h0001);
    check("t4a ev_coalesced", 32'(ev_coalesced), 32'h0);
    sw_in = 16'h0021;
    drops = 0;
    for (int k = 0; k < 14 && ev_mask != 16'h0021; k++) begin
      step();
      if (!ev_valid) drops++;
    end
    check("t4 valid held", 32'(drops), 32'h0);
    check("t4 ev_mask", 32'(ev_mask), 32'h0021);
    check("t4 ev_state", 32'(ev_state), 32'h0021);
    check("t4 ev_coalesced", 32'(ev_coalesced), 32'h1);
    check("t4 sw_state", 32'(sw_state), 32'h0021);
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    check("t4 valid after accept", 32'(ev_valid), 32'h0);
    check("t4 mask after accept", 32'(ev_mask), 32'h0);

    // 5: bit 7 flips on exactly the edge where a pending event is accepted.
    sw_in = 16'h0023;
    wait_valid(14, "t5a");
    check("t5a ev_mask", 32'(ev_mask), 32'h0002);
    sw_in = 16'h00A3;
    c0 = cyc;
    t1 = ((c0 + 3 + (DC - 1)) / DC) * DC;   // first tick seeing the new level
    fl = t1 + (SS - 1) * DC;                // tick on which bit 7 inverts
    while (cyc < fl - 1) step();
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    check("t5 valid stays", 32'(ev_valid), 32'h1);
    check("t5 ev_mask", 32'(ev_mask), 32'h0080);
    check("t5 ev_coalesced", 32'(ev_coalesced), 32'h0);
    check("t5 ev_state", 32'(ev_state), 32'h00A3);
    step();
    check("t5 fresh event held", 32'(ev_valid), 32'h1);
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    check("t5 valid after accept", 32'(ev_valid), 32'h0);

    // 6: reset drops a pending event; it reappears after debounce.
    sw_in = 16'h00A7;
    wait_valid(14, "t6a");
    check("t6a ev_mask", 32'(ev_mask), 32'h0004);
    do_reset(1);
    check("t6 rst ev_valid", 32'(ev_valid), 32'h0);
    check("t6 rst sw_state", 32'(sw_state), 32'h0);
    check("t6 rst ev_mask", 32'(ev_mask), 32'h0);
    wait_valid(2 + 12, "t6b");
    check("t6 ev_mask", 32'(ev_mask), 32'h00A7);
    check("t6 ev_state", 32'(ev_state), 32'h00A7);
    check("t6 ev_coalesced", 32'(ev_coalesced), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_switch_input_reader
`default_nettype wire

// File: doc/switch_input_reader.md
# switch_input_reader

Input-side counterpart of the board's LED output path: samples up to 16 slide switches, synchronises and debounces them, and reports each debounced change as an event through a valid/ready handshake. The processor or GPIO bridge in the demo block design consumes these events. It sits between the board pins and the processor-side peripheral, in the same clock domain as the LED path.

## Interface
- `WIDTH`, 16: number of switch inputs.
- `DEBOUNCE_CYCLES`, 1000: clock cycles per sample tick (10 µs at 100 MHz).
- `STABLE_SAMPLES`, 3: consecutive differing ticks required to accept a new level.
- `clock_rtl` in, 1: system clock.
- `reset_rtl_0_1` in, 1: synchronous, active-low reset.
- `sw_in` in, WIDTH: raw asynchronous switch pins.
- `sw_state` out, WIDTH: current debounced levels.
- `ev_valid` out, 1: an event is pending.
- `ev_ready` in, 1: the consumer accepts the event.
- `ev_state` out, WIDTH: debounced levels at the time of the most recent merged change.
- `ev_mask` out, WIDTH: bits that changed since the last accepted event.
- `ev_coalesced` out, 1: the pending event merged at least one later change.

## Operation
- **Synchroniser:** a 2-flop synchroniser on each `sw_in` bit; output `sync[i]`.
- **Tick counter:** counts `0..DEBOUNCE_CYCLES-1`. `tick` is high when count = `DEBOUNCE_CYCLES-1`, then the counter wraps to 0.
- **Per-bit debounce:** each bit has a stable level `stab[i]` and a counter `cnt[i]` of width clog2(`STABLE_SAMPLES`).
  - On a tick with `sync[i] != stab[i]`: `cnt[i]` increments.
  - On the tick where `cnt[i]` would reach `STABLE_SAMPLES`: `stab[i]` inverts and `cnt[i]` returns to 0.
  - On a tick with `sync[i] == stab[i]`: `cnt[i]` returns to 0.
  - Non-tick cycles: no change.
- `flip` is the combinational vector of bits that invert at this edge. `sw_state = stab`.
- **FSM, IDLE:**
  - `ev_valid` = 0.
  - If `flip != 0`: `ev_mask <= flip`, `ev_state <= next stab`, `ev_coalesced <= 0`, go to PEND.
- **FSM, PEND:**
  - `ev_valid` = 1. Outputs stay stable unless a merge occurs.
  - `ev_ready` and `flip == 0`: go to IDLE, `ev_mask <= 0`.
  - `ev_ready` and `flip != 0`: stay in PEND with a fresh event (`ev_mask <= flip`, `ev_state <= next stab`, `ev_coalesced <= 0`). No change is lost.
  - `!ev_ready` and `flip != 0`: `ev_mask <= ev_mask | flip`, `ev_state <= next stab`, `ev_coalesced <= 1`.
  - A bit that toggles twice while pending stays set in `ev_mask`, and `ev_state` shows its final level.

## Timing
- Reset, on a `clock_rtl` edge with `reset_rtl_0_1`=0:
  - sync flops, `stab`, `cnt`, the tick counter, `ev_mask`, `ev_state` and `ev_coalesced` all go to 0.
  - FSM goes to IDLE, `ev_valid` = 0, `sw_state` = 0.
- Reset mid-event drops the pending event. Switches held high through reset produce one event after debounce.
- The tick counter restarts at 0 when reset is released. The first tick occurs `DEBOUNCE_CYCLES` edges later.
- Latency from a clean input step to `sw_state`/`ev_valid` update:
  - `sync` reflects the step 2 edges after it.
  - `stab` inverts on the `STABLE_SAMPLES`-th tick at or after that point.
  - `sw_state`, `ev_valid`, `ev_state` and `ev_mask` all update on that same edge.
- Handshake:
  - Transfer occurs on an edge with `ev_valid && ev_ready`.
  - `ev_ready` may be held high permanently, giving one event per flip edge.
  - `ev_valid` never drops without a transfer, except on reset.
- Glitch shorter than `STABLE_SAMPLES` ticks: no `stab` change, no event.

## Structure
- Package `switch_input_pkg`:
  - Default constants `SW_WIDTH=16`, `SW_DEBOUNCE_CYCLES=1000`, `SW_STABLE_SAMPLES=3`.
  - Enum `ev_state_t {EV_IDLE, EV_PEND}`.
- Sub-module `input_debounce`, one bit:
  - Contains the synchroniser, `cnt` and `stab`.
  - Inputs: `tick`, raw bit. Outputs: `stab`, `flip`.
  - Instantiated WIDTH times by a generate loop.
- The tick counter and FSM live in the top.

## Test plan
Bench uses a 10 ns clock, `DEBOUNCE_CYCLES=4` and `STABLE_SAMPLES=3`.
1. Reset: hold `reset_rtl_0_1`=0 for 5 cycles with `sw_in`=16'hFFFF -> all outputs 0. After release, exactly one event with `ev_mask`=16'hFFFF and `ev_state`=16'hFFFF, within 2+12 cycles.
2. Clean step: `sw_in`=16'h0001 with `ev_ready`=1 -> a single-cycle `ev_valid` with `ev_mask`=16'h0001 and `ev_state`=16'h0001, arriving no later than 14 cycles after the step. `sw_state`=16'h0001 from the same edge.
3. Glitch: bit 3 high for 6 cycles, then low -> no event and `sw_state` unchanged.
4. Coalescing: `ev_ready`=0; bit 0 goes high, then bit 5 goes high after the event is raised -> `ev_mask`=16'h0021, `ev_state`=16'h0021, `ev_coalesced`=1. Assert `ev_ready` for 1 cycle -> `ev_valid` drops.
5. Simultaneous accept and flip: arrange for a new flip of bit 7 on the exact edge where `ev_ready` accepts -> `ev_valid` stays 1, `ev_mask`=16'h0080, `ev_coalesced`=0.
6. Reset mid-event: pending event with `ev_ready`=0, then assert reset for 1 cycle -> `ev_valid`=0. The event reappears after debounce if the switches are still non-zero.
